// File: rtl/fault_free_2.sv
// -----------------------------------------------------------------------------
// fault_free_2
//
// Purpose:
//   Small gate-level circuit K = f(A,B,C,D) with fault-injection controls on
//   the internal nets E, G and J. A clocked self-test sequencer evaluates one
//   latched test vector under four configurations:
//     - fault-free
//     - E stuck-at-0
//     - G stuck-at-0
//     - J stuck-at-1
//   It reports the four responses and per-fault detect flags.
//
// Ports:
//   clk            in   1  system clock, rising edge
//   rst_n          in   1  asynchronous active-low reset
//   A, B, C, D     in   1  primary inputs, test vector {A,B,C,D} (A = MSB)
//   G0             in   1  G control: 1 = normal, 0 = G forced to 0
//   E0             in   1  E control: 1 = normal, 0 = E forced to 0
//   J1             in   1  J control: 0 = normal, 1 = J forced to 1
//   K              out  1  combinational circuit output (external controls)
//   start          in   1  self-test request, sampled at rising edge
//   busy           out  1  self-test in progress
//   done           out  1  one-cycle pulse when word/flags are updated
//   word           out  4  [3] fault-free, [2] E s-a-0, [1] G s-a-0, [0] J s-a-1
//   det_e          out  1  word[3] != word[2]
//   det_g          out  1  word[3] != word[1]
//   det_j          out  1  word[3] != word[0]
// -----------------------------------------------------------------------------
module fault_free_2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       G0,
  input  logic       E0,
  input  logic       J1,
  output logic       K,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [3:0] word,
  output logic       det_e,
  output logic       det_g,
  output logic       det_j
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FF   = 3'd1,
    ST_E    = 3'd2,
    ST_G    = 3'd3,
    ST_J    = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // Netlist evaluation shared by the external K path and the self-test copy.
  function automatic logic netlist_k(input logic [3:0] vec,
                                     input logic       e0,
                                     input logic       g0,
                                     input logic       j1);
    logic e_net;
    logic g_net;
    logic j_net;
    logic h_net;
    e_net = vec[3] & vec[2] & e0;
    g_net = vec[1] & ~vec[0] & g0;
    j_net = (vec[2] & vec[0]) | j1;
    h_net = e_net & g_net;
    return h_net & ~j_net;
  endfunction

  state_t     state_q, state_d;
  logic [3:0] vec_q, vec_d;
  logic [3:0] word_q, word_d;
  logic [2:0] det_q, det_d;    // {e, g, j}
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       int_e0_s;
  logic       int_g0_s;
  logic       int_j1_s;
  logic       int_k_s;

  // External K path: purely combinational, independent of clock and reset.
  assign K = netlist_k({A, B, C, D}, E0, G0, J1);

  // Fault configuration of the internal copy, selected by the sequencer state.
  always_comb begin
    int_e0_s = 1'b1;
    int_g0_s = 1'b1;
    int_j1_s = 1'b0;
    case (state_q)
      ST_E:    int_e0_s = 1'b0;
      ST_G:    int_g0_s = 1'b0;
      ST_J:    int_j1_s = 1'b1;
      default: int_j1_s = 1'b0;
    endcase
  end

  assign int_k_s = netlist_k(vec_q, int_e0_s, int_g0_s, int_j1_s);

  // Sequencer next-state, vector latch, response capture and detect flags.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    word_d  = word_q;
    det_d   = det_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          vec_d   = {A, B, C, D};
          state_d = ST_FF;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FF: begin
        word_d[3] = int_k_s;
        state_d   = ST_E;
      end
      ST_E: begin
        word_d[2] = int_k_s;
        state_d   = ST_G;
      end
      ST_G: begin
        word_d[1] = int_k_s;
        state_d   = ST_J;
      end
      ST_J: begin
        word_d[0] = int_k_s;
        // The last response bit is not yet in word_q, so use it directly.
        det_d     = {word_q[3] ^ word_q[2],
                     word_q[3] ^ word_q[1],
                     word_q[3] ^ int_k_s};
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Status flags are decoded from the next state so they come straight off flops.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Sequencer state and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= 4'b0000;
      word_q  <= 4'b0000;
      det_q   <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      word_q  <= word_d;
      det_q   <= det_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign word  = word_q;
  assign det_e = det_q[2];
  assign det_g = det_q[1];
  assign det_j = det_q[0];

endmodule

// File: tb/tb_fault_free_2.sv
// -----------------------------------------------------------------------------
// tb_fault_free_2
//
// Self-checking bench for fault_free_2.
// Expected self-test results are pushed to a scoreboard queue when a start is
// driven and popped when done is observed.
// -----------------------------------------------------------------------------
module tb_fault_free_2;

  logic       clk;
  logic       rst_n;
  logic       A, B, C, D;
  logic       G0, E0, J1;
  logic       K;
  logic       start;
  logic       busy;
  logic       done;
  logic [3:0] word;
  logic       det_e, det_g, det_j;

  int checks_cnt = 0;
  int errors_cnt = 0;

  // Scoreboard entries: {word[3:0], det_e, det_g, det_j}.
  logic [6:0] sb_q[$];

  fault_free_2 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .G0    (G0),
    .E0    (E0),
    .J1    (J1),
    .K     (K),
    .start (start),
    .busy  (busy),
    .done  (done),
    .word  (word),
    .det_e (det_e),
    .det_g (det_g),
    .det_j (det_j)
  );

  // Clock generation, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks_cnt++;
    if (obs !== exp_v) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: K can only be 1 when D=0, in which case J reduces to J1.
  function automatic logic ref_k(input logic [3:0] v, input logic e0, input logic g0, input logic j1);
    return (v == 4'b1110) && e0 && g0 && !j1;
  endfunction

  function automatic logic [6:0] expect_run(input logic [3:0] v);
    logic ff, fe, fg, fj;
    ff = ref_k(v, 1'b1, 1'b1, 1'b0);
    fe = ref_k(v, 1'b0, 1'b1, 1'b0);
    fg = ref_k(v, 1'b1, 1'b0, 1'b0);
    fj = ref_k(v, 1'b1, 1'b1, 1'b1);
    return {ff, fe, fg, fj, ff ^ fe, ff ^ fg, ff ^ fj};
  endfunction

  // One self-test run; optionally disturbs A..D and re-pulses start mid-run.
  task automatic run_selftest(input logic [3:0] v, input bit disturb);
    int         done_cnt;
    int         lat;
    logic [6:0] exp_v;
    done_cnt = 0;
    lat      = 0;
    {A, B, C, D} = v;
    start = 1'b1;
    sb_q.push_back(expect_run(v));
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        start = 1'b0;
        check_val("busy_after_start", busy, 1);
      end
      if (disturb && n == 2) begin
        {A, B, C, D} = ~v;
        start = 1'b1;
      end
      if (disturb && n == 3) start = 1'b0;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          lat = n;
          check_val("sb_size", sb_q.size(), 1);
          if (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
            check_val("word", word, exp_v[6:3]);
            check_val("det_e", det_e, exp_v[2]);
            check_val("det_g", det_g, exp_v[1]);
            check_val("det_j", det_j, exp_v[0]);
          end
        end
      end
    end
    check_val("done_latency", lat, 5);
    check_val("done_pulses", done_cnt, 1);
    check_val("busy_idle", busy, 0);
    sb_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    {A, B, C, D} = 4'b0000;
    G0 = 1'b1;
    E0 = 1'b1;
    J1 = 1'b0;

    // Reset state.
    #12;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_word", word, 0);
    check_val("rst_det", {det_e, det_g, det_j}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // K path with vector 1110 under each external fault control.
    {A, B, C, D} = 4'b1110;
    #1 check_val("k_ff", K, 1);
    E0 = 1'b0;
    #1 check_val("k_e0", K, 0);
    E0 = 1'b1; G0 = 1'b0;
    #1 check_val("k_g0", K, 0);
    G0 = 1'b1; J1 = 1'b1;
    #1 check_val("k_j1", K, 0);
    J1 = 1'b0;

    // Sweep all vectors with normal controls.
    for (int i = 0; i < 16; i++) begin
      {A, B, C, D} = i[3:0];
      #1 check_val($sformatf("k_sweep_%0d", i), K, ref_k(i[3:0], 1'b1, 1'b1, 1'b0));
    end

    @(posedge clk);
    #1;
    run_selftest(4'b1110, 1'b0);

    // Results hold while idle.
    repeat (3) @(posedge clk);
    #1;
    check_val("hold_word", word, 4'b1000);
    check_val("hold_det", {det_e, det_g, det_j}, 3'b111);

    run_selftest(4'b0000, 1'b0);
    run_selftest(4'b1111, 1'b0);

    // External fault controls must not affect the internal copy.
    E0 = 1'b0; G0 = 1'b0; J1 = 1'b1;
    run_selftest(4'b1110, 1'b1);
    E0 = 1'b1; G0 = 1'b1; J1 = 1'b0;
    run_selftest(4'b0110, 1'b1);

    // Reset during S_G abandons the run.
    {A, B, C, D} = 4'b1110;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("busy_in_sg", busy, 1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_done", done, 0);
    check_val("mid_rst_word", word, 0);
    check_val("mid_rst_det", {det_e, det_g, det_j}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("post_rst_busy", busy, 0);
    run_selftest(4'b1110, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
